idli_uart_rx_m: RTL and testbench

UART receiver for the idli core: deserialises 8N1 frames from the external RX pin, buffers received bytes in a small FIFO, and presents them to the core's nibble-serial datapath as `sqi_data_t` nibbles over a valid/accept handshake. It is the receive-side counterpart of `idli_uart_m`, sits between the `o_top_uart_rx`-adjacent input pin and the execute stage, and fills the RX slot currently open in the top level.

---
 rtl/idli_pkg.sv | 17 +
 rtl/idli_uart_rx_fifo_m.sv | 52 +++++
 rtl/idli_uart_rx_m.sv | 121 ++++++++++++
 tb/tb_idli_uart_rx_m.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared idli types and constants: nibble datapath type, UART receiver FSM states
// and the baud divisor used by both UART transmitter and receiver.
package idli_pkg;

    typedef logic [3:0] sqi_data_t;

    typedef enum logic [1:0] {
        UART_RX_IDLE  = 2'd0,
        UART_RX_START = 2'd1,
        UART_RX_DATA  = 2'd2,
        UART_RX_STOP  = 2'd3
    } uart_rx_state_t;

    // Core clocks per UART bit; TX and RX must agree on this.
    localparam int UART_BIT_CYCLES = 16;

endpackage

// File: rtl/idli_uart_rx_fifo_m.sv
// Byte-wide receive FIFO with a nibble-serial read port (low nibble first).
// Handshake: a nibble transfers when vld && acp; vld = not empty; data holds while vld && !acp.
module idli_uart_rx_fifo_m
    import idli_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wdata,
    output logic       full,
    output sqi_data_t  data,
    output logic       vld,
    input  logic       acp
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic [7:0]  head;
    logic        nib_sel;
    logic        xfer;
    logic        pop;

    assign vld  = (wr_ptr != rd_ptr);
    assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head = mem[rd_ptr[AW-1:0]];
    assign data = !vld ? '0 : (nib_sel ? head[7:4] : head[3:0]);
    assign xfer = vld && acp;
    // The byte leaves the FIFO only once its high nibble has been taken.
    assign pop  = xfer && nib_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            nib_sel <= 1'b0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop)           rd_ptr <= rd_ptr + 1'b1;
            if (xfer)          nib_sel <= !nib_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/idli_uart_rx_m.sv
// 8N1 UART receiver: synchroniser, frame FSM and bit timing; received bytes go
// into idli_uart_rx_fifo_m and leave as nibbles over a valid/accept handshake.
module idli_uart_rx_m
    import idli_pkg::*;
#(
    parameter int BIT_CYCLES = UART_BIT_CYCLES,
    parameter int FIFO_DEPTH = 4
) (
    input  logic      i_uart_rx_gck,
    input  logic      i_uart_rx_rst_n,
    input  logic      i_uart_rx,
    output sqi_data_t o_uart_rx_data,
    output logic      o_uart_rx_vld,
    input  logic      i_uart_rx_acp,
    output logic      o_uart_rx_ferr,
    output logic      o_uart_rx_ovf
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CYCLES - 1);

    logic           rx_meta;
    logic           rx_sync;
    logic           rx_prev;
    logic [1:0]     sync_fill;
    logic           fall;
    uart_rx_state_t state;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           fifo_full;
    logic           push;

    // rx_prev only follows real samples, so a line already low at reset release is not an edge.
    always_ff @(posedge i_uart_rx_gck or negedge i_uart_rx_rst_n) begin
        if (!i_uart_rx_rst_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            rx_meta   <= i_uart_rx;
            rx_sync   <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            rx_prev   <= sync_fill[1] ? rx_sync : 1'b0;
        end
    end

    assign fall = rx_prev && !rx_sync;
    assign push = (state == UART_RX_STOP) && (cnt == '0) && rx_sync && !fifo_full;

    always_ff @(posedge i_uart_rx_gck or negedge i_uart_rx_rst_n) begin
        if (!i_uart_rx_rst_n) begin
            state          <= UART_RX_IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            o_uart_rx_ferr <= 1'b0;
            o_uart_rx_ovf  <= 1'b0;
        end else begin
            o_uart_rx_ferr <= 1'b0;
            o_uart_rx_ovf  <= 1'b0;
            case (state)
                UART_RX_IDLE: begin
                    if (fall) begin
                        state <= UART_RX_START;
                        cnt   <= HALF_LOAD;
                    end
                end
                UART_RX_START: begin
                    if (cnt == '0) begin
                        if (!rx_sync) begin
                            state   <= UART_RX_DATA;
                            cnt     <= FULL_LOAD;
                            bit_idx <= '0;
                        end else begin
                            state <= UART_RX_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                UART_RX_DATA: begin
                    if (cnt == '0) begin
                        shreg   <= {rx_sync, shreg[7:1]};
                        cnt     <= FULL_LOAD;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= UART_RX_STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                UART_RX_STOP: begin
                    if (cnt == '0) begin
                        state <= UART_RX_IDLE;
                        if (!rx_sync)      o_uart_rx_ferr <= 1'b1;
                        else if (fifo_full) o_uart_rx_ovf <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= UART_RX_IDLE;
            endcase
        end
    end

    idli_uart_rx_fifo_m #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_uart_rx_gck),
        .rst_n (i_uart_rx_rst_n),
        .push  (push),
        .wdata (shreg),
        .full  (fifo_full),
        .data  (o_uart_rx_data),
        .vld   (o_uart_rx_vld),
        .acp   (i_uart_rx_acp)
    );

endmodule

// File: tb/tb_idli_uart_rx_m.sv
// Directed bench for idli_uart_rx_m: serial frames in, nibble stream and error pulses checked.
module tb_idli_uart_rx_m;
    import idli_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      rx;
    sqi_data_t data;
    logic      vld;
    logic      acp;
    logic      ferr;
    logic      ovf;

    int n_checks = 0;
    int n_bad    = 0;

    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    int         xfers      = 0;
    int         vld_cycles = 0;
    int         ferr_cnt   = 0;
    int         ovf_cnt    = 0;
    int         stall_bad  = 0;
    logic       prev_stall = 1'b0;
    logic [3:0] prev_data  = '0;

    idli_uart_rx_m #(
        .BIT_CYCLES (16),
        .FIFO_DEPTH (4)
    ) dut (
        .i_uart_rx_gck   (clk),
        .i_uart_rx_rst_n (rst_n),
        .i_uart_rx       (rx),
        .o_uart_rx_data  (data),
        .o_uart_rx_vld   (vld),
        .i_uart_rx_acp   (acp),
        .o_uart_rx_ferr  (ferr),
        .o_uart_rx_ovf   (ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: samples mid-cycle, values are those seen by the next rising edge
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (vld && acp) begin
                got_q.push_back(data);
                xfers++;
            end
            if (vld)  vld_cycles++;
            if (ferr) ferr_cnt++;
            if (ovf)  ovf_cnt++;
            if (prev_stall && (!vld || data != prev_data)) stall_bad++;
            prev_stall = vld && !acp;
            prev_data  = data;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_nibbles(input string tag);
        check_val({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            check_val(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();
    endtask

    // driver tasks
    task automatic hold_bit(input logic v);
        rx = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int v0, f0, o0, x0;
        rst_n = 1'b0;
        rx    = 1'b1;
        acp   = 1'b0;
        idle(3);
        check_val("rst_vld", 32'(vld), 0);
        check_val("rst_data", 32'(data), 0);
        check_val("rst_ferr", 32'(ferr), 0);
        check_val("rst_ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        idle(5);

        // single frame, acp held high
        acp = 1'b1;
        v0 = vld_cycles; f0 = ferr_cnt; o0 = ovf_cnt;
        send_byte(8'hA5, 1'b1);
        idle(10);
        exp_q.push_back(4'h5); exp_q.push_back(4'hA);
        expect_nibbles("single");
        check_val("single_vld_cycles", 32'(vld_cycles - v0), 2);
        check_val("single_ferr", 32'(ferr_cnt - f0), 0);
        check_val("single_ovf", 32'(ovf_cnt - o0), 0);

        // back-to-back frames with backpressure
        acp = 1'b0;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        idle(4);
        check_val("b2b_vld_stalled", 32'(vld), 1);
        check_val("b2b_data_stalled", 32'(data), 32'h2);
        x0 = xfers;
        acp = 1'b1;
        idle(6);
        #2;
        check_val("b2b_consecutive", 32'(xfers - x0), 6);
        check_val("b2b_drained", 32'(vld), 0);
        exp_q.push_back(4'h2); exp_q.push_back(4'h1);
        exp_q.push_back(4'h4); exp_q.push_back(4'h3);
        exp_q.push_back(4'h6); exp_q.push_back(4'h5);
        expect_nibbles("b2b");
        check_val("b2b_stable", 32'(stall_bad), 0);
        @(negedge clk);

        // glitch: 4 low cycles
        f0 = ferr_cnt; o0 = ovf_cnt; x0 = xfers;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        check_val("glitch_xfers", 32'(xfers - x0), 0);
        check_val("glitch_pulses", 32'((ferr_cnt - f0) + (ovf_cnt - o0)), 0);
        check_val("glitch_state", 32'(dut.state), 32'(UART_RX_IDLE));

        // framing error then a good frame
        v0 = vld_cycles; f0 = ferr_cnt;
        send_byte(8'h3C, 1'b0);
        idle(10);
        check_val("ferr_pulses", 32'(ferr_cnt - f0), 1);
        check_val("ferr_no_vld", 32'(vld_cycles - v0), 0);
        send_byte(8'h81, 1'b1);
        idle(10);
        exp_q.push_back(4'h1); exp_q.push_back(4'h8);
        expect_nibbles("after_ferr");

        // overflow: five bytes into a four-deep FIFO
        acp = 1'b0;
        o0 = ovf_cnt; f0 = ferr_cnt;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        idle(4);
        check_val("ovf_pulses", 32'(ovf_cnt - o0), 1);
        check_val("ovf_no_ferr", 32'(ferr_cnt - f0), 0);
        acp = 1'b1;
        idle(20);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(4'(i));
            exp_q.push_back(4'h0);
        end
        expect_nibbles("ovf_drain");

        // reset in the middle of data bit 3 of 0xFF
        hold_bit(1'b0);
        hold_bit(1'b1); hold_bit(1'b1); hold_bit(1'b1);
        idle(8);
        check_val("mid_state_data", 32'(dut.state), 32'(UART_RX_DATA));
        rst_n = 1'b0;
        idle(3);
        check_val("mid_rst_vld", 32'(vld), 0);
        check_val("mid_rst_data", 32'(data), 0);
        check_val("mid_rst_ferr", 32'(ferr), 0);
        check_val("mid_rst_ovf", 32'(ovf), 0);
        check_val("mid_rst_state", 32'(dut.state), 32'(UART_RX_IDLE));
        rx = 1'b1;
        rst_n = 1'b1;
        x0 = xfers; f0 = ferr_cnt;
        idle(200);
        check_val("mid_no_output", 32'(xfers - x0), 0);
        check_val("mid_no_ferr", 32'(ferr_cnt - f0), 0);
        send_byte(8'h7E, 1'b1);
        idle(10);
        exp_q.push_back(4'hE); exp_q.push_back(4'h7);
        expect_nibbles("after_reset");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
